if_fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I pipeline.
- Generates the PC and fetches instructions over a request/response instruction-memory interface.
- Presents {pc, instr} to the ID stage.
- Consumes the branch decision and target produced in ID, redirecting the PC and flushing wrong-path instructions.

---
 rtl/if_fetch_stage_pkg.sv | 28 ++
 rtl/if_fetch_stage_skid_buffer.sv | 42 ++++
 rtl/if_fetch_stage.sv | 166 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] a);
    return a + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_fetch_stage_skid_buffer.sv
// One-entry {pc, instr} holding register; catches a response that lands while ID is stalled.
module if_skid_buffer
  import if_fetch_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clr,
  input  fetch_pkt_t load_pkt,
  output logic       valid,
  output fetch_pkt_t pkt
);

  logic       valid_q, valid_d;
  fetch_pkt_t pkt_q, pkt_d;

  // Clear wins over load so a redirect always empties the entry.
  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pkt_d   = load_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign valid = valid_q;
  assign pkt   = pkt_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch + IF/ID register with single-outstanding imem requests and ID redirect.
// Define IF_PERF_CNT_EN to add perf_fetch_cnt / perf_flush_cnt outputs.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [XLEN-1:0] id_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_flush_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;

  logic       skid_load, skid_clr, skid_valid;
  fetch_pkt_t skid_pkt, rsp_pkt;
  logic       rsp_keep, req_c, accept;

  assign rsp_keep = (state_q == WAIT) && imem_rvalid;
  assign rsp_pkt  = '{pc: req_pc_q, instr: imem_rdata};
  assign req_c    = ((state_q == IDLE) || rsp_keep) && !stall && !skid_valid
                    && !branch_taken && !rst;
  assign accept   = req_c && imem_ready;

  if_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clr      (skid_clr),
    .load_pkt (rsp_pkt),
    .valid    (skid_valid),
    .pkt      (skid_pkt)
  );

  // Next-state: redirect beats stall; IF/ID prefers the skid over a fresh response.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_instr_d    = id_instr_q;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;

    if (branch_taken) begin
      pc_d       = pc_align(branch_target);
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      skid_clr   = 1'b1;
      if (state_q == WAIT) begin
        state_d = imem_rvalid ? IDLE : DROP;
      end
    end else begin
      if (accept) begin
        req_pc_d = pc_q;
        pc_d     = pc_inc(pc_q);
        state_d  = WAIT;
      end else if (rsp_keep || ((state_q == DROP) && imem_rvalid)) begin
        state_d = IDLE;
      end

      if (stall) begin
        skid_load = rsp_keep;
      end else if (skid_valid) begin
        skid_clr      = 1'b1;
        id_valid_d    = 1'b1;
        id_pc_d       = skid_pkt.pc;
        id_pc_plus4_d = pc_inc(skid_pkt.pc);
        id_instr_d    = skid_pkt.instr;
      end else if (rsp_keep) begin
        id_valid_d    = 1'b1;
        id_pc_d       = rsp_pkt.pc;
        id_pc_plus4_d = pc_inc(rsp_pkt.pc);
        id_instr_d    = rsp_pkt.instr;
      end else begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= XLEN'(4);
      id_instr_q    <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_instr_q    <= id_instr_d;
    end
  end

  assign imem_req    = req_c;
  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_instr    = id_instr_q;

`ifdef IF_PERF_CNT_EN
  logic            id_load;
  logic [XLEN-1:0] perf_fetch_q, perf_fetch_d;
  logic [XLEN-1:0] perf_flush_q, perf_flush_d;

  assign id_load = !branch_taken && !stall && (skid_valid || rsp_keep);

  always_comb begin
    perf_fetch_d = perf_fetch_q + XLEN'(id_load);
    perf_flush_d = perf_flush_q + XLEN'(branch_taken);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding means the memory broke the protocol.
  rvalid_in_idle_a: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (state_q == IDLE)));
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus random stall/redirect/reset traffic.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_pc_plus4   (id_pc_plus4),
    .id_instr      (id_instr)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory contents and single-slot response model
  logic        pend;
  logic        pend_killed;
  logic [31:0] pend_addr;
  int          pend_wait;
  int          lat_min, lat_max, ready_pct;

  // Program-order reference: responses that must still reach ID, in order
  logic [31:0] ready_q[$];
  logic [31:0] exp_fetch_pc;
  logic        exp_id_valid;
  logic [31:0] exp_id_pc, exp_id_instr;
  int          n_loaded, n_flush, total_loaded;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h8) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic        acc;
    logic [31:0] req_addr;
    logic [31:0] front;
    imem_rvalid = !rst && pend && (pend_wait == 0);
    imem_rdata  = imem_rvalid ? memf(pend_addr) : 32'h0;
    imem_ready  = ($urandom_range(99) < ready_pct);
    #1;
    if (rst || stall || branch_taken) check_eq("req_blocked", 32'(imem_req), 32'd0);
    if (imem_req) check_eq("single_outstanding", 32'(pend && !imem_rvalid), 32'd0);
    acc      = imem_req && imem_ready;
    req_addr = imem_addr;
    if (acc) check_eq("fetch_addr", imem_addr, exp_fetch_pc);
    @(posedge clk);
    #1;
    if (rst) begin
      pend = 1'b0;
      ready_q.delete();
      exp_fetch_pc = RESET_PC;
      exp_id_valid = 1'b0;
      exp_id_pc    = 32'h0;
      exp_id_instr = NOP;
      n_loaded = 0;
      n_flush  = 0;
    end else begin
      if (imem_rvalid) begin
        if (!pend_killed && !branch_taken) ready_q.push_back(pend_addr);
        pend = 1'b0;
      end else if (pend && pend_wait > 0) begin
        pend_wait--;
      end
      if (acc) begin
        pend         = 1'b1;
        pend_killed  = 1'b0;
        pend_addr    = req_addr;
        pend_wait    = int'($urandom_range(lat_max, lat_min)) - 1;
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      if (branch_taken) begin
        n_flush++;
        exp_fetch_pc = branch_target & ~32'd3;
        ready_q.delete();
        if (pend) pend_killed = 1'b1;
        exp_id_valid = 1'b0;
        exp_id_instr = NOP;
      end else if (!stall) begin
        if (ready_q.size() > 0) begin
          front = ready_q.pop_front();
          exp_id_valid = 1'b1;
          exp_id_pc    = front;
          exp_id_instr = memf(front);
          n_loaded++;
          total_loaded++;
        end else begin
          exp_id_valid = 1'b0;
          exp_id_instr = NOP;
        end
      end
    end
    check_eq("id_valid", 32'(id_valid), 32'(exp_id_valid));
    check_eq("id_pc", id_pc, exp_id_pc);
    check_eq("id_instr", id_instr, exp_id_instr);
    check_eq("id_pc_plus4", id_pc_plus4, exp_id_pc + 32'd4);
`ifdef IF_PERF_CNT_EN
    check_eq("perf_fetch_cnt", perf_fetch_cnt, 32'(n_loaded));
    check_eq("perf_flush_cnt", perf_flush_cnt, 32'(n_flush));
`endif
  endtask

  task automatic run_until_valid(input string tag, input logic [31:0] want_pc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!id_valid && n < 40);
    check_eq({tag, "_valid"}, 32'(id_valid), 32'd1);
    check_eq({tag, "_pc"}, id_pc, want_pc);
  endtask

  initial begin
    pend = 1'b0; pend_killed = 1'b0; pend_addr = '0; pend_wait = 0;
    exp_fetch_pc = RESET_PC; exp_id_valid = 1'b0; exp_id_pc = '0; exp_id_instr = NOP;
    n_loaded = 0; n_flush = 0; total_loaded = 0;
    lat_min = 1; lat_max = 1; ready_pct = 100;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    tick(); tick();
    rst = 1'b0;

    // Zero-wait streaming: first valid two edges after reset release
    tick(); check_eq("first_bubble", 32'(id_valid), 32'd0);
    tick(); check_eq("first_pc", id_pc, 32'h0);
    tick(); check_eq("second_pc", id_pc, 32'h4);

    // Stall while the pc 0x8 response arrives; it must come out of the skid
    stall = 1'b1;
    repeat (3) tick();
    check_eq("stall_hold_pc", id_pc, 32'h4);
    stall = 1'b0;
    tick();
    check_eq("skid_pc", id_pc, 32'h8);
    check_eq("skid_instr", id_instr, 32'h0050_0093);

    // Redirect while a slow response is outstanding
    lat_min = 4; lat_max = 4;
    tick();
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    check_eq("redir_bubble", 32'(id_valid), 32'd0);
    branch_taken = 1'b0;
    lat_min = 1; lat_max = 1;
    run_until_valid("redir", 32'h100);

    // Redirect coinciding with stall and a full skid
    tick(); tick();
    stall = 1'b1;
    tick();
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    check_eq("stall_redir_bubble", 32'(id_valid), 32'd0);
    stall = 1'b0; branch_taken = 1'b0;
    run_until_valid("stall_redir", 32'h40);

    // Misaligned target and PC wrap
    branch_taken = 1'b1; branch_target = 32'h103;
    tick();
    branch_taken = 1'b0;
    run_until_valid("align", 32'h100);
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    tick();
    branch_taken = 1'b0;
    run_until_valid("wrap", 32'hFFFF_FFFC);
    check_eq("wrap_plus4", id_pc_plus4, 32'h0);
    tick();
    check_eq("wrap_next_pc", id_pc, 32'h0);

    // Random traffic with variable latency, back-pressure and occasional reset
    lat_min = 1; lat_max = 3; ready_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(199) == 0);
      stall         = ($urandom_range(99) < 20);
      branch_taken  = ($urandom_range(99) < 6);
      branch_target = $urandom;
      tick();
    end
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    check_eq("stream_progress", 32'(total_loaded > 200), 32'd1);

    rst = 1'b1;
    tick();
    check_eq("final_reset_valid", 32'(id_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
